// File: rtl/dht11_env_monitor.sv
// dht11_env_monitor: moving-average filter over DHT11 readings with hysteretic
// temperature/humidity alarm bands, plausibility rejection and stale-sensor detection.
module dht11_env_monitor #(
    parameter int AVG_LOG2     = 2,
    parameter int TEMP_HI      = 30,
    parameter int TEMP_LO      = 18,
    parameter int HUM_HI       = 70,
    parameter int HUM_LO       = 30,
    parameter int HYST         = 2,
    parameter int STALE_CYCLES = 100000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_data_in,
    input  logic        i_valid,
    output logic [7:0]  o_temp_avg,
    output logic [7:0]  o_hum_avg,
    output logic        o_avg_valid,
    output logic [1:0]  o_temp_state,
    output logic [1:0]  o_hum_state,
    output logic        o_stale,
    output logic [7:0]  o_reject_cnt,
    output logic        o_alert
);
    localparam int N  = 1 << AVG_LOG2;
    localparam int SW = 8 + AVG_LOG2;
    localparam int CW = $clog2(STALE_CYCLES + 1);
    localparam logic [7:0] T_HI   = 8'(TEMP_HI);
    localparam logic [7:0] T_LO   = 8'(TEMP_LO);
    localparam logic [7:0] T_HI_X = 8'(TEMP_HI - HYST);
    localparam logic [7:0] T_LO_X = 8'(TEMP_LO + HYST);
    localparam logic [7:0] H_HI   = 8'(HUM_HI);
    localparam logic [7:0] H_LO   = 8'(HUM_LO);
    localparam logic [7:0] H_HI_X = 8'(HUM_HI - HYST);
    localparam logic [7:0] H_LO_X = 8'(HUM_LO + HYST);

    typedef enum logic [1:0] {WARMUP, RUN, STALE} state_t;

    state_t              r_state, w_next;
    logic [7:0]          r_tbuf [N];
    logic [7:0]          r_hbuf [N];
    logic [AVG_LOG2-1:0] r_wptr;
    logic [SW-1:0]       r_tsum, r_hsum, w_tsum, w_hsum;
    logic [CW-1:0]       r_cnt;
    logic [7:0]          r_tavg, r_havg, r_reject, w_tavg, w_havg;
    logic [1:0]          r_tstate, r_hstate;
    logic                r_avg_valid, w_ok, w_take, w_upd, w_hit;

    // 10 = high alarm, 01 = low alarm; leaving an alarm needs HYST margin
    function automatic logic [1:0] f_band(input logic [1:0] cur, input logic [7:0] avg,
                                          input logic [7:0] hi, lo, hi_x, lo_x);
        if (cur == 2'b10) return (avg <= lo) ? 2'b01 : (avg <= hi_x) ? 2'b00 : 2'b10;
        if (cur == 2'b01) return (avg >= hi) ? 2'b10 : (avg >= lo_x) ? 2'b00 : 2'b01;
        return (avg >= hi) ? 2'b10 : (avg <= lo) ? 2'b01 : 2'b00;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= WARMUP;
        else          r_state <= w_next;
    end

    always_comb begin
        w_ok   = (i_data_in[15:8] <= 8'd100) && (i_data_in[7:0] <= 8'd60);
        w_take = i_valid && w_ok;
        w_upd  = w_take && (r_state == RUN || r_wptr == '1);
        w_hit  = !i_valid && r_state != STALE && r_cnt == CW'(STALE_CYCLES - 1);
        w_tsum = r_tsum + SW'(i_data_in[7:0]) - SW'(r_tbuf[r_wptr]);
        w_hsum = r_hsum + SW'(i_data_in[15:8]) - SW'(r_hbuf[r_wptr]);
        w_tavg = w_tsum[AVG_LOG2 +: 8];
        w_havg = w_hsum[AVG_LOG2 +: 8];
        w_next = w_hit ? STALE :
                 (r_state == STALE) ? (i_valid ? (w_upd ? RUN : WARMUP) : STALE) :
                 w_upd ? RUN : r_state;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_tbuf[i] <= '0;
                r_hbuf[i] <= '0;
            end
            r_wptr      <= '0;
            r_tsum      <= '0;
            r_hsum      <= '0;
            r_cnt       <= '0;
            r_tavg      <= '0;
            r_havg      <= '0;
            r_tstate    <= 2'b00;
            r_hstate    <= 2'b00;
            r_reject    <= '0;
            r_avg_valid <= 1'b0;
        end else begin
            r_avg_valid <= w_upd;
            r_cnt       <= (i_valid || w_hit) ? '0 : (r_state == STALE) ? r_cnt : r_cnt + 1'b1;
            if (i_valid && !w_ok && r_reject != 8'hFF) r_reject <= r_reject + 1'b1;
            if (w_hit) begin
                for (int i = 0; i < N; i++) begin
                    r_tbuf[i] <= '0;
                    r_hbuf[i] <= '0;
                end
                r_wptr <= '0;
                r_tsum <= '0;
                r_hsum <= '0;
            end else if (w_take) begin
                r_tbuf[r_wptr] <= i_data_in[7:0];
                r_hbuf[r_wptr] <= i_data_in[15:8];
                r_wptr         <= r_wptr + 1'b1;
                r_tsum         <= w_tsum;
                r_hsum         <= w_hsum;
            end
            if (w_upd) begin
                r_tavg   <= w_tavg;
                r_havg   <= w_havg;
                r_tstate <= f_band(r_tstate, w_tavg, T_HI, T_LO, T_HI_X, T_LO_X);
                r_hstate <= f_band(r_hstate, w_havg, H_HI, H_LO, H_HI_X, H_LO_X);
            end
        end
    end

    assign o_temp_avg   = r_tavg;
    assign o_hum_avg    = r_havg;
    assign o_avg_valid  = r_avg_valid;
    assign o_temp_state = r_tstate;
    assign o_hum_state  = r_hstate;
    assign o_stale      = (r_state == STALE);
    assign o_reject_cnt = r_reject;
    assign o_alert      = (r_tstate != 2'b00) || (r_hstate != 2'b00) || o_stale;
endmodule

// File: tb/tb_dht11_env_monitor.sv
// tb_dht11_env_monitor: directed scenarios plus randomized traffic checked every cycle
// against a queue-based reference model of the monitor.
module tb_dht11_env_monitor;
    localparam int N  = 4;
    localparam int SC = 50;
    localparam int HY = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in = '0;
    logic        valid = 1'b0;
    logic [7:0]  temp_avg, hum_avg, reject_cnt;
    logic        avg_valid, stale, alert;
    logic [1:0]  temp_state, hum_state;

    int n_checks = 0;
    int n_fail = 0;

    int tq[$];
    int hq[$];
    int m_tavg, m_havg, m_ts, m_hs, m_rej, m_idle;
    bit m_stale, m_avgv;

    dht11_env_monitor #(.AVG_LOG2(2), .STALE_CYCLES(SC)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data_in(data_in), .i_valid(valid),
        .o_temp_avg(temp_avg), .o_hum_avg(hum_avg), .o_avg_valid(avg_valid),
        .o_temp_state(temp_state), .o_hum_state(hum_state), .o_stale(stale),
        .o_reject_cnt(reject_cnt), .o_alert(alert)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int band(input int cur, input int a, input int hi, input int lo);
        if (cur == 2) return (a <= lo) ? 1 : (a <= hi - HY) ? 0 : 2;
        if (cur == 1) return (a >= hi) ? 2 : (a >= lo + HY) ? 0 : 1;
        return (a >= hi) ? 2 : (a <= lo) ? 1 : 0;
    endfunction

    task automatic model_clear();
        tq.delete();
        hq.delete();
        m_tavg = 0; m_havg = 0; m_ts = 0; m_hs = 0;
        m_rej = 0; m_idle = 0; m_stale = 0; m_avgv = 0;
    endtask

    task automatic model_cycle(input bit v, input int h, input int t);
        int st, sh;
        m_avgv = 0;
        if (v) begin
            m_idle = 0;
            m_stale = 0;
            if (h <= 100 && t <= 60) begin
                tq.push_back(t);
                hq.push_back(h);
                if (tq.size() > N) begin
                    void'(tq.pop_front());
                    void'(hq.pop_front());
                end
                if (tq.size() == N) begin
                    st = 0; sh = 0;
                    foreach (tq[i]) begin
                        st += tq[i];
                        sh += hq[i];
                    end
                    m_tavg = st / N;
                    m_havg = sh / N;
                    m_ts = band(m_ts, m_tavg, 30, 18);
                    m_hs = band(m_hs, m_havg, 70, 30);
                    m_avgv = 1;
                end
            end else if (m_rej < 255) m_rej++;
        end else if (!m_stale) begin
            m_idle++;
            if (m_idle == SC) begin
                m_stale = 1;
                m_idle = 0;
                tq.delete();
                hq.delete();
            end
        end
    endtask

    task automatic compare_all();
        check("avg_valid", avg_valid, m_avgv);
        check("avgs", {temp_avg, hum_avg}, {m_tavg[7:0], m_havg[7:0]});
        check("states", {temp_state, hum_state}, {m_ts[1:0], m_hs[1:0]});
        check("stale", stale, m_stale);
        check("alert", alert, (m_ts != 0) || (m_hs != 0) || m_stale);
        check("reject_cnt", reject_cnt, m_rej);
    endtask

    task automatic step(input bit v, input int h, input int t);
        valid = v;
        data_in = {h[7:0], t[7:0]};
        @(posedge clk);
        #1;
        model_cycle(v, h, t);
        compare_all();
        valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_clear();
        compare_all();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        model_clear();
        do_reset();
        // basic averaging
        step(1, 50, 20);
        step(1, 50, 22);
        step(1, 50, 24);
        check("r037_early", avg_valid, 0);
        step(1, 50, 26);
        check("r037_avgv", avg_valid, 1);
        check("r037_tavg", temp_avg, 23);
        check("r037_havg", hum_avg, 50);
        check("r037_alert", alert, 0);
        step(0, 0, 0);
        check("r037_single", avg_valid, 0);
        // hysteresis on the hot side
        repeat (4) step(1, 50, 31);
        check("r038_hot", temp_state, 2);
        check("r038_alert", alert, 1);
        repeat (4) step(1, 50, 29);
        check("r038_avg29", temp_avg, 29);
        check("r038_hold", temp_state, 2);
        repeat (4) step(1, 50, 28);
        check("r038_avg28", temp_avg, 28);
        check("r038_ok", temp_state, 0);
        // implausible samples
        step(1, 8'h80, 25);
        check("r039_rej1", reject_cnt, 1);
        check("r039_held", temp_avg, 28);
        check("r039_noavgv", avg_valid, 0);
        repeat (299) step(1, 8'h80, 25);
        check("r039_sat", reject_cnt, 255);
        // stale entry and recovery
        repeat (SC - 1) step(0, 0, 0);
        check("r040_notyet", stale, 0);
        step(0, 0, 0);
        check("r040_stale", stale, 1);
        check("r040_alert", alert, 1);
        check("r040_held", temp_avg, 28);
        repeat (5) step(0, 0, 0);
        step(1, 40, 20);
        check("r040_clear", stale, 0);
        step(1, 40, 20);
        step(1, 40, 20);
        check("r040_wait", avg_valid, 0);
        step(1, 40, 20);
        check("r040_avgv", avg_valid, 1);
        // valid on the cycle the stale count would be reached
        repeat (SC - 1) step(0, 0, 0);
        step(1, 40, 22);
        check("r041_nostale", stale, 0);
        step(0, 0, 0);
        check("r041_after", stale, 0);
        // reset in the middle of a window
        step(1, 60, 25);
        step(1, 60, 25);
        do_reset();
        check("r042_tavg", temp_avg, 0);
        check("r042_rej", reject_cnt, 0);
        repeat (3) step(1, 60, 25);
        check("r042_wait", avg_valid, 0);
        step(1, 60, 25);
        check("r042_avgv", avg_valid, 1);
        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                repeat (SC + $urandom_range(0, 5) - 3) step(0, 0, 0);
            end else if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 9) == 0)
                    step(1, $urandom_range(0, 255), $urandom_range(55, 255));
                else
                    step(1, $urandom_range(15, 85), $urandom_range(10, 40));
            end else begin
                step(0, 0, 0);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dht11_env_monitor.md
DHT11_ENV_MONITOR -- requirements
Module: dht11_env_monitor

Interface
REQ-001 Parameter AVG_LOG2, default 2: the moving-average window is 2**AVG_LOG2 samples.
REQ-002 Parameter TEMP_HI, default 30: HOT entry threshold in degC.
REQ-003 Parameter TEMP_LO, default 18: COLD entry threshold in degC.
REQ-004 Parameter HUM_HI, default 70: HUMID entry threshold in %RH.
REQ-005 Parameter HUM_LO, default 30: DRY entry threshold in %RH.
REQ-006 Parameter HYST, default 2: hysteresis band for leaving HOT/COLD/HUMID/DRY.
REQ-007 Parameter STALE_CYCLES, default 100000000: clk cycles with no accepted-or-rejected sample before stale is declared.
REQ-008 Port clk, input, 1: single system clock; all state on rising edge.
REQ-009 Port rst, input, 1: reset is asynchronous and active-low.
REQ-010 Port data_in, input, 16: the sensor controller reading; [15:8] is integer humidity and [7:0] is integer temperature.
REQ-011 Port valid, input, 1: a one-cycle pulse qualifying data_in.
REQ-012 Port temp_avg, output, 8: windowed mean temperature.
REQ-013 Port hum_avg, output, 8: windowed mean humidity.
REQ-014 Port avg_valid, output, 1: one-cycle pulse marking updated averages and states.
REQ-015 Port temp_state, output, 2: temperature state; 00 OK, 01 COLD, 10 HOT, 11 never driven.
REQ-016 Port hum_state, output, 2: humidity state; 00 OK, 01 DRY, 10 HUMID, 11 never driven.
REQ-017 Port stale, output, 1: level, sensor silent for STALE_CYCLES.
REQ-018 Port reject_cnt, output, 8: saturating count of implausible samples.
REQ-019 Port alert, output, 1: level, high when temp_state!=OK, hum_state!=OK, or stale.

Function
REQ-020 The block SHALL run a control FSM with states WARMUP, RUN and STALE; the reset state is WARMUP.
REQ-021 A sample is plausible only if humidity<=100 and temperature<=60; an implausible sample SHALL increment reject_cnt (saturating at 255), SHALL NOT enter the window, and SHALL restart the stale counter.
REQ-022 Each plausible sample SHALL be written into a circular buffer of 2**AVG_LOG2 entries per channel; per-channel sums of width 8+AVG_LOG2 SHALL be updated as sum + new - evicted.
REQ-023 In WARMUP, the FSM SHALL count fills; avg_valid SHALL NOT pulse until the window is full; on the fill that completes the window, the FSM SHALL move to RUN.
REQ-024 Averages SHALL be sum >> AVG_LOG2, truncated.
REQ-025 Latency: a plausible valid at cycle N (with the window full after it) SHALL produce updated temp_avg/hum_avg/states and an avg_valid pulse at cycle N+1.
REQ-026 State transitions SHALL be evaluated on the new average in the same update.
REQ-027 Temperature transitions: OK->HOT if avg>=TEMP_HI; OK->COLD if avg<=TEMP_LO; HOT->OK if avg<=TEMP_HI-HYST; COLD->OK if avg>=TEMP_LO+HYST; HOT<->COLD direct if the opposite entry threshold is met.
REQ-028 Humidity transitions SHALL follow REQ-027 with HUM_HI/HUM_LO mapped to HUMID/DRY.
REQ-029 The stale counter SHALL reset on every valid pulse and otherwise increment.
REQ-030 When the stale counter reaches STALE_CYCLES, the FSM SHALL enter STALE: stale=1, window and sums cleared, fill count 0.
REQ-031 temp_avg, hum_avg and the states SHALL hold their last values while in STALE.
REQ-032 In STALE, the next valid SHALL clear stale and return the FSM to WARMUP, and a plausible sample SHALL be taken as the first fill.
REQ-033 If valid coincides with the counter reaching STALE_CYCLES, valid SHALL win: there is no STALE entry.
REQ-034 valid pulses on consecutive cycles SHALL each be processed; no sample is dropped.

Reset
REQ-035 On rst low, all outputs, buffers, sums, counters and the FSM SHALL clear immediately: averages 0, states OK, stale 0, alert 0, reject_cnt 0, FSM WARMUP.
REQ-036 Reset deassertion mid-window SHALL restart warmup from an empty window.

Verification
REQ-037 Temperatures 20,22,24,26 with humidity 50 -> single avg_valid one cycle after the 4th valid; temp_avg=23, hum_avg=50, both states OK, alert 0.
REQ-038 Four samples at temp 31 -> temp_state HOT, alert 1; then samples at temp 29 until the average is 29 -> remains HOT; samples at temp 28 until the average is 28 -> OK.
REQ-039 Sample with humidity 0x80 -> reject_cnt 1, averages unchanged, no avg_valid; 300 rejects -> reject_cnt 255.
REQ-040 STALE_CYCLES=50 with no valid for 50 cycles -> stale 1, alert 1, averages held; next valid -> stale 0, avg_valid only after 4 more plausible samples.
REQ-041 valid on the cycle the stale count hits 50 -> stale stays 0.
REQ-042 rst pulsed low after 2 of 4 samples -> outputs 0 asynchronously; avg_valid only after 4 new samples.
